// File: rtl/delay_timer_ctrl_pkg.sv
// Shared types and defaults for the BlackJack delay-timer controller.
package bj_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, RELEASE} state_t;
    typedef enum logic {OWN_A, OWN_B} owner_t;

    localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
    localparam int unsigned TICK_HZ_DEFAULT = 2_000;
    localparam int unsigned DELAY_TWO_SEC   = 4000;
    localparam int unsigned DELAY_HALF_SEC  = 1000;

    function automatic int unsigned prescale_of(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/delay_timer_ctrl_if.sv
// Request/grant/done bundle between the requesters and the shared delay timer.
interface delay_timer_ctrl_if #(
    parameter int unsigned WIDTH = 12
);
    logic             i_ReqA;
    logic             i_ReqB;
    logic             i_Abort;
    logic             o_GntA;
    logic             o_GntB;
    logic             o_DoneA;
    logic             o_DoneB;
    logic             o_Busy;
    logic             o_Tick;
    logic [WIDTH-1:0] o_Count;

    modport master (
        output i_ReqA, i_ReqB, i_Abort,
        input  o_GntA, o_GntB, o_DoneA, o_DoneB, o_Busy, o_Tick, o_Count
    );

    modport slave (
        input  i_ReqA, i_ReqB, i_Abort,
        output o_GntA, o_GntB, o_DoneA, o_DoneB, o_Busy, o_Tick, o_Count
    );
endinterface

// File: rtl/delay_timer_ctrl_tick_prescaler.sv
// Divides the system clock into a one-cycle tick strobe every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST     = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 2);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("tick_prescaler: PRESCALE must be at least 2");
    end

    logic [CW-1:0] cnt;

    // tick is registered one cycle ahead so it is high exactly while cnt == LAST
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == PRE_LAST);
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/delay_timer_ctrl.sv
// Arbitrates two delay requesters (A over B) onto one tick counter and returns a done pulse.
module delay_timer_ctrl
    import bj_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT,
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned DELAY_A = DELAY_TWO_SEC,
    parameter int unsigned DELAY_B = DELAY_HALF_SEC
) (
    input  logic              clk_50M,
    input  logic              i_Reset,
    delay_timer_ctrl_if.slave bus
);
    localparam int unsigned PRESCALE = prescale_of(CLK_HZ, TICK_HZ);
    localparam logic [WIDTH-1:0] TGT_A = WIDTH'(DELAY_A);
    localparam logic [WIDTH-1:0] TGT_B = WIDTH'(DELAY_B);

    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_ratio
        $error("delay_timer_ctrl: CLK_HZ must be a multiple of TICK_HZ");
    end
    if (DELAY_A > (1 << WIDTH) - 1 || DELAY_B > (1 << WIDTH) - 1) begin : g_bad_delay
        $error("delay_timer_ctrl: DELAY_A/DELAY_B exceed WIDTH-bit counter range");
    end

    state_t           state;
    owner_t           owner;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             gnt_a, gnt_b, done_a, done_b, busy;
    logic             tick;
    logic             pre_clear, pre_en;
    logic             owner_req;
    logic             abortable;
    logic [WIDTH-1:0] owner_delay;
    logic [WIDTH-1:0] count_inc;

    assign owner_req   = (owner == OWN_A) ? bus.i_ReqA : bus.i_ReqB;
    assign owner_delay = (owner == OWN_A) ? TGT_A : TGT_B;
    assign count_inc   = count + WIDTH'(1);
    assign abortable   = (state == LOAD) || (state == RUN) || (state == DONE);

    assign pre_clear = (state == LOAD) || bus.i_Abort;
    assign pre_en    = (state == RUN);

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk_50M),
        .rst    (i_Reset),
        .clear  (pre_clear),
        .enable (pre_en),
        .tick   (tick)
    );

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state  <= IDLE;
            owner  <= OWN_A;
            target <= '0;
            count  <= '0;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            // abort takes priority over expiry, so it is resolved before the state case
            if (bus.i_Abort && abortable) begin
                state <= IDLE;
                gnt_a <= 1'b0;
                gnt_b <= 1'b0;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.i_ReqA || bus.i_ReqB) begin
                            owner <= bus.i_ReqA ? OWN_A : OWN_B;
                            busy  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        count  <= '0;
                        target <= owner_delay;
                        gnt_a  <= (owner == OWN_A);
                        gnt_b  <= (owner == OWN_B);
                        if (owner_delay == '0) begin
                            done_a <= (owner == OWN_A);
                            done_b <= (owner == OWN_B);
                            state  <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            count <= count_inc;
                            if (count_inc == target) begin
                                done_a <= (owner == OWN_A);
                                done_b <= (owner == OWN_B);
                                state  <= DONE;
                            end
                        end
                    end
                    DONE: state <= RELEASE;
                    RELEASE: begin
                        // a still-held request must not retrigger the timer
                        if (!owner_req) begin
                            state <= IDLE;
                            gnt_a <= 1'b0;
                            gnt_b <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_GntA  = gnt_a;
    assign bus.o_GntB  = gnt_b;
    assign bus.o_DoneA = done_a;
    assign bus.o_DoneB = done_b;
    assign bus.o_Busy  = busy;
    assign bus.o_Tick  = tick;
    assign bus.o_Count = count;
endmodule

// File: tb/tb_delay_timer_ctrl.sv
// Bench for delay_timer_ctrl: vector table, directed corner sequences, and random traffic vs an elapsed-time model.
module tb_delay_timer_ctrl;
    localparam int P  = 10;
    localparam int DA = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ra = 1'b0, rb = 1'b0, ab = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_timer_ctrl_if #(.WIDTH(4)) bus ();
    assign bus.i_ReqA  = ra;
    assign bus.i_ReqB  = rb;
    assign bus.i_Abort = ab;

    delay_timer_ctrl #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .WIDTH   (4),
        .DELAY_A (DA),
        .DELAY_B (DB)
    ) dut (
        .clk_50M (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    // {GntA, GntB, DoneA, DoneB, Busy, Tick, Count[3:0]}
    function automatic logic [9:0] act_vec();
        return {bus.o_GntA, bus.o_GntB, bus.o_DoneA, bus.o_DoneB, bus.o_Busy, bus.o_Tick, bus.o_Count};
    endfunction

    task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %03h want %03h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: owner (0 none, 1 A, 2 B) and cycles elapsed since the grant decision.
    int m_own = 0, m_age = 0, m_hold = 0;

    function automatic int tgt(input int own);
        return (own == 1) ? DA : DB;
    endfunction

    function automatic int done_age(input int own);
        return tgt(own) * P + 1;
    endfunction

    function automatic bit own_req(input int own);
        return (own == 1) ? ra : rb;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_own <= 0; m_age <= 0; m_hold <= 0;
        end else if (m_own == 0) begin
            if (ra) begin m_own <= 1; m_age <= 0; end
            else if (rb) begin m_own <= 2; m_age <= 0; end
        end else if (ab && m_age <= done_age(m_own)) begin
            m_own <= 0; m_hold <= 0;
        end else if (m_age > done_age(m_own) && !own_req(m_own)) begin
            m_own <= 0; m_hold <= tgt(m_own);
        end else begin
            m_age <= m_age + 1;
        end
    end

    function automatic logic [9:0] model_exp();
        logic [9:0] v;
        int r, t;
        v = '0;
        if (m_own == 0) begin
            v[3:0] = 4'(m_hold);
        end else if (m_age == 0) begin
            v[5] = 1'b1;
            v[3:0] = 4'(m_hold);
        end else begin
            r = m_age - 1;
            t = tgt(m_own);
            v[5] = 1'b1;
            if (m_own == 1) v[9] = 1'b1; else v[8] = 1'b1;
            if (r < t * P) begin
                v[4] = (r % P == P - 1);
                v[3:0] = 4'(r / P);
            end else begin
                if (r == t * P) begin
                    if (m_own == 1) v[7] = 1'b1; else v[6] = 1'b1;
                end
                v[3:0] = 4'(t);
            end
        end
        return v;
    endfunction

    always @(negedge clk) if (chk_en) check_vec("model", act_vec(), model_exp());

    function automatic bit sig(input int which);
        case (which)
            0: return bus.o_DoneA;
            1: return bus.o_DoneB;
            2: return bus.o_GntB;
            3: return bus.o_GntA;
            default: return !bus.o_Busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input int bound, input string name, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (sig(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: event not seen within %0d cycles", name, bound);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       ra;
        logic       rb;
        logic       ab;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t0, t1, t2;
        bit seen;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, "reset_idle"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, "reset_masks_req"};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, "abort_in_idle"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h020, "b_load"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "abort_in_load"};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h020, "b_reload"};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h120, "b_run_grant"};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h120, "b_no_preempt"};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h000, "abort_in_run"};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h020, "a_load"};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h220, "a_run_grant"};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, "reset_mid_run"};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'h020, "both_load"};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h220, "a_wins_priority"};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "abort_a_run"};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, "idle_after_abort"};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; ra = vecs[i].ra; rb = vecs[i].rb; ab = vecs[i].ab;
            @(negedge clk);
            check_vec(vecs[i].name, act_vec(), vecs[i].exp);
        end

        // A alone: done latency, final count, release on request drop
        ra = 1'b1; c0 = cyc;
        wait_for(0, 100, "s1_wait_done_a", t0);
        check_int("s1_done_latency", t0 - c0, 42);
        check_int("s1_count", int'(bus.o_Count), 4);
        while (cyc < c0 + 45) @(negedge clk);
        ra = 1'b0;
        @(negedge clk);
        check_int("s1_busy_drop", int'(bus.o_Busy), 0);

        // simultaneous requests: A first, then B
        ra = 1'b1; rb = 1'b1;
        wait_for(0, 100, "s2_wait_done_a", t0);
        ra = 1'b0;
        wait_for(2, 20, "s2_wait_gnt_b", t1);
        wait_for(1, 40, "s2_wait_done_b", t2);
        check_int("s2_b_latency", t2 - t1, 20);
        rb = 1'b0;
        wait_for(4, 10, "s2_wait_idle", t0);

        // A arrives mid-run of B
        rb = 1'b1;
        wait_for(2, 10, "s3_wait_gnt_b", t0);
        repeat (5) @(negedge clk);
        ra = 1'b1;
        wait_for(1, 40, "s3_wait_done_b", t1);
        check_int("s3_b_undisturbed", t1 - t0, 20);
        rb = 1'b0;
        wait_for(4, 10, "s3_wait_idle", t1);
        wait_for(3, 10, "s3_wait_gnt_a", t2);
        check_int("s3_a_after_idle", t2 - t1, 2);

        // held request after done must not retrigger
        wait_for(0, 60, "s4_wait_done_a", t0);
        repeat (10) @(negedge clk);
        check_vec("s4_no_retrigger", act_vec(), 10'h224);
        ra = 1'b0;
        wait_for(4, 5, "s4_wait_idle", t0);
        ra = 1'b1;
        wait_for(3, 5, "s4_regrant", t0);

        // abort 25 cycles into the run, then abort on the final tick
        repeat (25) @(negedge clk);
        ab = 1'b1;
        @(negedge clk);
        check_int("s5_abort_busy", int'(bus.o_Busy), 0);
        check_int("s5_abort_count", int'(bus.o_Count), 0);
        ab = 1'b0; ra = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.o_DoneA) seen = 1'b1;
        end
        check_int("s5_no_done", int'(seen), 0);
        ra = 1'b1; c0 = cyc;
        repeat (41) @(negedge clk);
        check_int("s5_final_tick", int'(bus.o_Tick), 1);
        ab = 1'b1;
        @(negedge clk);
        check_vec("s5_abort_final", act_vec(), 10'h000);
        ab = 1'b0; ra = 1'b0;

        // reset mid-run with request still held
        @(negedge clk);
        ra = 1'b1;
        wait_for(3, 5, "s6_wait_gnt_a", t0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_vec("s6_reset_all", act_vec(), 10'h000);
        rst = 1'b0;
        wait_for(3, 5, "s6_regrant", t0);
        check_int("s6_restart_count", int'(bus.o_Count), 0);
        ab = 1'b1;
        @(negedge clk);
        ab = 1'b0; ra = 1'b0;

        // random traffic checked each cycle against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) ra = ~ra;
            if ($urandom_range(0, 29) == 0) rb = ~rb;
            ab  = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0; ab = 1'b0; ra = 1'b0; rb = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
